// File: rtl/diff_job_sequencer.sv
// Job FIFO, ap_ctrl_hs launcher and result collector for one diff-equation solver.
// A watchdog aborts a hung solver and emits a flagged zero result.
module diff_job_sequencer #(
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          ap_clk,
    input  logic          ap_rst,

    input  logic          job_valid,
    output logic          job_ready,
    input  logic [DW-1:0] job_x,
    input  logic [DW-1:0] job_dx,
    input  logic [DW-1:0] job_u,
    input  logic [DW-1:0] job_a,
    input  logic [DW-1:0] job_y,

    output logic          solver_start,
    output logic          solver_rst,
    input  logic          solver_done,
    input  logic          solver_ready,
    input  logic [DW-1:0] solver_return,
    output logic [DW-1:0] solver_x,
    output logic [DW-1:0] solver_dx,
    output logic [DW-1:0] solver_u,
    output logic [DW-1:0] solver_a,
    output logic [DW-1:0] solver_y,

    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_timeout,
    output logic [15:0]   jobs_done,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam int EW = 5 * DW;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [WW-1:0] wd;
    logic          abort_pulse;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic done_hit;
    logic wd_hit;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign job_ready = !full && !ap_rst;
    assign push      = job_valid && job_ready;

    assign done_hit = (state == S_RUN) && solver_done;
    assign wd_hit   = (state == S_RUN) && !solver_done && (wd == WD_LAST);
    assign pop      = done_hit || wd_hit;

    assign {solver_x, solver_dx, solver_u, solver_a, solver_y} =
        mem[rd_ptr[AW-1:0]];

    assign solver_start = (state == S_RUN);
    assign solver_rst   = ap_rst | abort_pulse;
    assign res_valid    = (state == S_OUT);
    assign busy         = !ap_rst && ((state != S_IDLE) || !empty);

    // Storage is not reset; only the pointers define occupancy.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {job_x, job_dx, job_u, job_a, job_y};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            wd          <= '0;
            abort_pulse <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            jobs_done   <= '0;
        end else begin
            abort_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state <= S_RUN;
                        wd    <= '0;
                    end
                end
                S_RUN: begin
                    // A done on the last watchdog cycle still wins.
                    if (solver_done) begin
                        res_data    <= solver_return;
                        res_timeout <= 1'b0;
                        state       <= S_OUT;
                    end else if (wd == WD_LAST) begin
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        abort_pulse <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        jobs_done <= jobs_done + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = solver_ready;

endmodule
